// File: rtl/tx_tlp_arbiter_pango.sv
// tx_tlp_arbiter_pango
//   Packet-granular round-robin arbiter sharing the single TX Classic TLP
//   channel of the Pango PCIe translation layer among C_NUM_SRC producers.
//   A grant is held from the first beat until the end-flag beat is accepted,
//   so TLPs are never interleaved. Framing violations raise a sticky flag.
//
// Ports
//   CLK, RST_N              clock, async active-low reset
//   SRC_TLP*                per-source beat, valid, start/end flags, end offset
//   SRC_TLP_READY           per-source accept (only the granted source sees it)
//   TX_TLP*                 muxed beat towards the translation layer
//   TX_TLP_READY            downstream accept
//   GRANT                   registered one-hot grant, zero when idle
//   BUSY                    a TLP is in flight
//   FRAME_ERR               sticky framing error, cleared only by reset
module tx_tlp_arbiter_pango #(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_NUM_SRC        = 3
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic [C_NUM_SRC*C_PCI_DATA_WIDTH-1:0] SRC_TLP,
  input  logic [C_NUM_SRC-1:0]                  SRC_TLP_VALID,
  input  logic [C_NUM_SRC-1:0]                  SRC_TLP_START_FLAG,
  input  logic [C_NUM_SRC-1:0]                  SRC_TLP_END_FLAG,
  input  logic [C_NUM_SRC*2-1:0]                SRC_TLP_END_OFFSET,
  output logic [C_NUM_SRC-1:0]                  SRC_TLP_READY,
  output logic [C_PCI_DATA_WIDTH-1:0]           TX_TLP,
  output logic                                  TX_TLP_VALID,
  output logic                                  TX_TLP_START_FLAG,
  output logic [1:0]                            TX_TLP_START_OFFSET,
  output logic                                  TX_TLP_END_FLAG,
  output logic [1:0]                            TX_TLP_END_OFFSET,
  input  logic                                  TX_TLP_READY,
  output logic [C_NUM_SRC-1:0]                  GRANT,
  output logic                                  BUSY,
  output logic                                  FRAME_ERR
);

  localparam int N  = C_NUM_SRC;
  localparam int W  = C_PCI_DATA_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state;
  logic [N-1:0]  grant;
  logic [PW-1:0] ptr;
  logic          first_beat;
  logic          frame_err;

  // Round-robin pick: first valid source starting at ptr, wrapping mod N.
  logic [N-1:0]  pick;
  logic [PW-1:0] ptr_nxt;
  logic          any_vld;
  int            idx;

  always_comb begin
    pick    = '0;
    ptr_nxt = ptr;
    any_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_vld && SRC_TLP_VALID[idx]) begin
        any_vld   = 1'b1;
        pick[idx] = 1'b1;
        ptr_nxt   = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Output mux driven purely by the registered grant; a zero grant (idle or
  // in reset) forces every TX output low with no clock needed.
  logic [W-1:0] tx_data;
  logic         tx_vld, tx_st, tx_en;
  logic [1:0]   tx_off;

  always_comb begin
    tx_data = '0;
    tx_vld  = 1'b0;
    tx_st   = 1'b0;
    tx_en   = 1'b0;
    tx_off  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        tx_data = SRC_TLP[i*W +: W];
        tx_vld  = SRC_TLP_VALID[i];
        tx_st   = SRC_TLP_START_FLAG[i];
        tx_en   = SRC_TLP_END_FLAG[i];
        tx_off  = SRC_TLP_END_OFFSET[i*2 +: 2];
      end
    end
  end

  logic accept;
  assign accept = tx_vld & TX_TLP_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      grant      <= '0;
      ptr        <= '0;
      first_beat <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_vld) begin
            grant      <= pick;
            ptr        <= ptr_nxt;
            first_beat <= 1'b1;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (accept) begin
            first_beat <= 1'b0;
            // First beat must carry start; later beats must not.
            if (first_beat != tx_st) frame_err <= 1'b1;
            if (tx_en) begin
              grant <= '0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign SRC_TLP_READY       = grant & {N{TX_TLP_READY}};
  assign TX_TLP              = tx_data;
  assign TX_TLP_VALID        = tx_vld;
  assign TX_TLP_START_FLAG   = tx_st;
  assign TX_TLP_START_OFFSET = 2'd0;
  assign TX_TLP_END_FLAG     = tx_en;
  assign TX_TLP_END_OFFSET   = tx_off;
  assign GRANT               = grant;
  assign BUSY                = (state == S_BUSY);
  assign FRAME_ERR           = frame_err;

endmodule

// File: tb/tb_tx_tlp_arbiter_pango.sv
// Scoreboard bench for tx_tlp_arbiter_pango: stimulus queues TLPs per source
// and pushes the hand-ordered expected output beats; a negedge monitor pops
// and compares whenever TX_TLP_VALID is presented.
module tb_tx_tlp_arbiter_pango;

  localparam int N = 3;

  logic             CLK, RST_N;
  logic [N*128-1:0] SRC_TLP;
  logic [N-1:0]     SRC_TLP_VALID, SRC_TLP_START_FLAG, SRC_TLP_END_FLAG;
  logic [N*2-1:0]   SRC_TLP_END_OFFSET;
  logic [N-1:0]     SRC_TLP_READY;
  logic [127:0]     TX_TLP;
  logic             TX_TLP_VALID, TX_TLP_START_FLAG, TX_TLP_END_FLAG;
  logic [1:0]       TX_TLP_START_OFFSET, TX_TLP_END_OFFSET;
  logic             TX_TLP_READY;
  logic [N-1:0]     GRANT;
  logic             BUSY, FRAME_ERR;

  tx_tlp_arbiter_pango #(.C_PCI_DATA_WIDTH(128), .C_NUM_SRC(N)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .SRC_TLP(SRC_TLP), .SRC_TLP_VALID(SRC_TLP_VALID),
    .SRC_TLP_START_FLAG(SRC_TLP_START_FLAG), .SRC_TLP_END_FLAG(SRC_TLP_END_FLAG),
    .SRC_TLP_END_OFFSET(SRC_TLP_END_OFFSET), .SRC_TLP_READY(SRC_TLP_READY),
    .TX_TLP(TX_TLP), .TX_TLP_VALID(TX_TLP_VALID),
    .TX_TLP_START_FLAG(TX_TLP_START_FLAG), .TX_TLP_START_OFFSET(TX_TLP_START_OFFSET),
    .TX_TLP_END_FLAG(TX_TLP_END_FLAG), .TX_TLP_END_OFFSET(TX_TLP_END_OFFSET),
    .TX_TLP_READY(TX_TLP_READY), .GRANT(GRANT), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [127:0] data;
    logic         st;
    logic         en;
    logic [1:0]   off;
  } beat_t;

  typedef struct {
    beat_t      b;
    logic [2:0] grant;
  } exp_t;

  beat_t srcq[N][$];
  exp_t  sb[$];
  logic  rdy_pat[$];
  logic [N-1:0] fire;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  exp_t mon_e;
  int   gap = 0;
  bit   after_end = 1'b0;
  bit   chk_gap = 1'b0;

  always @(negedge CLK) begin
    if (RST_N) begin
      if (TX_TLP_VALID) begin
        if (chk_gap && after_end && TX_TLP_START_FLAG) chk("bubble_cycles", 128'(gap), 128'd1);
        after_end = 1'b0;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 128'(TX_TLP_VALID), 128'd0);
        end else begin
          mon_e = sb[0];
          chk("tx_data", TX_TLP, mon_e.b.data);
          chk("tx_flags", {124'd0, TX_TLP_START_FLAG, TX_TLP_END_FLAG, TX_TLP_END_OFFSET},
              {124'd0, mon_e.b.st, mon_e.b.en, mon_e.b.off});
          chk("grant", 128'(GRANT), 128'(mon_e.grant));
          chk("src_ready", 128'(SRC_TLP_READY), TX_TLP_READY ? 128'(mon_e.grant) : 128'd0);
          chk("start_offset", 128'(TX_TLP_START_OFFSET), 128'd0);
          if (TX_TLP_READY) begin
            void'(sb.pop_front());
            if (TX_TLP_END_FLAG) begin
              after_end = 1'b1;
              gap = 0;
            end
          end
        end
      end else if (after_end) begin
        gap++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        SRC_TLP[128*i +: 128]        = srcq[i][0].data;
        SRC_TLP_VALID[i]             = 1'b1;
        SRC_TLP_START_FLAG[i]        = srcq[i][0].st;
        SRC_TLP_END_FLAG[i]          = srcq[i][0].en;
        SRC_TLP_END_OFFSET[2*i +: 2] = srcq[i][0].off;
      end else begin
        SRC_TLP[128*i +: 128]        = '0;
        SRC_TLP_VALID[i]             = 1'b0;
        SRC_TLP_START_FLAG[i]        = 1'b0;
        SRC_TLP_END_FLAG[i]          = 1'b0;
        SRC_TLP_END_OFFSET[2*i +: 2] = '0;
      end
    end
  endtask

  // One clock: record which sources were accepted, advance them after the edge.
  task automatic step();
    @(negedge CLK);
    fire = SRC_TLP_VALID & SRC_TLP_READY;
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++)
      if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    TX_TLP_READY = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    drive_srcs();
  endtask

  // Queue a TLP on a source; the first n_exp beats are expected at the output.
  task automatic add_tlp(input int src, input int pkt, input int nb, input int n_exp, input bit bad);
    for (int b = 0; b < nb; b++) begin
      beat_t x;
      exp_t  e;
      x.data = {32'(src), 32'(pkt), 32'(b), 32'hC0DE_0000 + 32'(b)};
      x.st   = (b == 0) && !bad;
      x.en   = (b == nb - 1);
      x.off  = 2'((src + b) % 4);
      srcq[src].push_back(x);
      if (b < n_exp) begin
        e.b     = x;
        e.grant = 3'(1 << src);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((sb.size() > 0 || srcq[0].size() > 0 || srcq[1].size() > 0 ||
            srcq[2].size() > 0 || BUSY) && cyc < 200) begin
      step();
      cyc++;
    end
    chk(name, 128'(cyc >= 200), 128'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    RST_N = 1'b0;
    TX_TLP_READY = 1'b1;
    SRC_TLP = '0; SRC_TLP_VALID = '0; SRC_TLP_START_FLAG = '0;
    SRC_TLP_END_FLAG = '0; SRC_TLP_END_OFFSET = '0;
    #12;
    chk("rst_grant", 128'(GRANT), 128'd0);
    chk("rst_busy", 128'(BUSY), 128'd0);
    chk("rst_frame_err", 128'(FRAME_ERR), 128'd0);
    chk("rst_tx_valid", 128'(TX_TLP_VALID), 128'd0);
    chk("rst_src_ready", 128'(SRC_TLP_READY), 128'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    step();

    // Round-robin from P=0: grants 0,1,2,0,1,2 with one bubble each.
    chk_gap = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++) add_tlp(s, p, 1, 1, 1'b0);
    drive_srcs();
    drain("rr_done");
    chk_gap = 1'b0;
    step();

    // Single source: 3-beat TLP, grant one cycle after valid.
    add_tlp(0, 10, 3, 3, 1'b0);
    drive_srcs();
    chk("ss_grant_t0", 128'(GRANT), 128'd0);
    step();
    chk("ss_grant_t1", 128'(GRANT), 128'b001);
    chk("ss_busy_t1", 128'(BUSY), 128'd1);
    step();
    step();
    step();
    chk("ss_idle_busy", 128'(BUSY), 128'd0);
    chk("ss_idle_grant", 128'(GRANT), 128'd0);
    drain("ss_done");

    // Backpressure on a 4-beat TLP from source 1.
    add_tlp(1, 20, 4, 4, 1'b0);
    drive_srcs();
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    drain("bp_done");

    // Framing error: source 2 first beat lacks start flag.
    chk("fe_before", 128'(FRAME_ERR), 128'd0);
    add_tlp(2, 30, 2, 2, 1'b1);
    drive_srcs();
    drain("fe_done");
    chk("fe_set", 128'(FRAME_ERR), 128'd1);
    add_tlp(1, 31, 2, 2, 1'b0);
    drive_srcs();
    drain("fe_next_done");
    chk("fe_sticky", 128'(FRAME_ERR), 128'd1);

    // Reset during beat 2 of a 5-beat TLP from source 0.
    add_tlp(0, 40, 5, 1, 1'b0);
    drive_srcs();
    begin
      int cyc = 0;
      do begin
        step();
        cyc++;
      end while (sb.size() > 0 && cyc < 20);
      chk("mr_beat1_timeout", 128'(cyc >= 20), 128'd0);
    end
    #2;
    RST_N = 1'b0;
    #1;
    chk("mr_tx_valid", 128'(TX_TLP_VALID), 128'd0);
    chk("mr_grant", 128'(GRANT), 128'd0);
    chk("mr_busy", 128'(BUSY), 128'd0);
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive_srcs();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    chk("mr_frame_err", 128'(FRAME_ERR), 128'd0);
    add_tlp(0, 50, 1, 1, 1'b0);
    add_tlp(1, 51, 1, 1, 1'b0);
    drive_srcs();
    drain("mr_after_done");

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_tlp_arbiter_pango.md
# tx_tlp_arbiter_pango

Packet-granular round-robin arbiter that shares the single TX Classic TLP channel of the Pango PCIe translation layer between `C_NUM_SRC` TLP producers, such as the read-request, write and completion engines. It sits directly upstream of the translation layer's `TX_TLP*` inputs. A grant is held from the first beat until the end-flag beat of one TLP is accepted, so TLPs are never interleaved. It also flags framing violations from the sources.

## Interface
Parameters:
- `C_PCI_DATA_WIDTH`, default 128: TLP beat width in bits. Only 128 is supported.
- `C_NUM_SRC`, default 3: number of requesters. Legal range is 2..4.

Ports:
- `CLK` in 1: the single clock.
- `RST_N` in 1: asynchronous reset, active-low.
- `SRC_TLP` in `C_NUM_SRC*128`: source beats; source i occupies `[128*i +: 128]`.
- `SRC_TLP_VALID` in `C_NUM_SRC`: per-source beat valid.
- `SRC_TLP_START_FLAG` in `C_NUM_SRC`: marks the first beat of a TLP.
- `SRC_TLP_END_FLAG` in `C_NUM_SRC`: marks the last beat of a TLP.
- `SRC_TLP_END_OFFSET` in `C_NUM_SRC*2`: last valid dword index of the end beat.
- `SRC_TLP_READY` out `C_NUM_SRC`: per-source beat accept.
- `TX_TLP` out 128: muxed beat, to the translation layer.
- `TX_TLP_VALID` out 1: muxed valid.
- `TX_TLP_START_FLAG` out 1: muxed start flag.
- `TX_TLP_START_OFFSET` out 2: constant 0.
- `TX_TLP_END_FLAG` out 1: muxed end flag.
- `TX_TLP_END_OFFSET` out 2: muxed end offset.
- `TX_TLP_READY` in 1: downstream accept.
- `GRANT` out `C_NUM_SRC`: registered one-hot grant; all zero when idle.
- `BUSY` out 1: high while a TLP is in flight.
- `FRAME_ERR` out 1: sticky framing error; cleared only by reset.

## Operation
- The FSM has two states, IDLE and BUSY. A beat is "accepted" when `TX_TLP_VALID & TX_TLP_READY`.
- Round-robin pointer `P` (clog2 of `C_NUM_SRC` bits):
  - P is the highest-priority index.
  - Search order is P, P+1, … with wrap modulo `C_NUM_SRC`.
- **IDLE:**
  - All `SRC_TLP_READY` are 0 and `TX_TLP_VALID` is 0.
  - If any `SRC_TLP_VALID` is high, the first valid source j in search order is captured into `GRANT` (one-hot).
  - P is set to (j+1) mod `C_NUM_SRC` and the state moves to BUSY.
  - If no source is valid, the block stays in IDLE with P unchanged.
- **BUSY with grant g:**
  - `TX_TLP*` = source g's signals.
  - `SRC_TLP_READY[g]` = `TX_TLP_READY`; all other ready bits are 0.
  - Other sources' valids are ignored; their beats are held, not dropped.
- **End of TLP:** an accepted beat with `TX_TLP_END_FLAG` = 1 moves the FSM to IDLE and clears `GRANT`. This includes single-beat TLPs, where start and end are on the same beat.
- **Framing check:** `FRAME_ERR` is set when any of the following holds:
  - the first accepted beat after grant has start flag = 0;
  - a later accepted beat in the same TLP has start flag = 1.
  
  Forwarding continues unchanged after an error; the arbiter still waits for the end flag.
- **Reset:**
  - Asynchronous assertion forces IDLE immediately, including mid-packet; the partial TLP is abandoned.
  - On reset: `GRANT` = 0, `BUSY` = 0, P = 0, `FRAME_ERR` = 0, `TX_TLP_VALID` = 0, `SRC_TLP_READY` = 0.

## Timing
- All registered state is in `CLK`: FSM, `GRANT`, P, `FRAME_ERR`, and the first-beat flag.
- Output muxes and ready routing are combinational from the registered `GRANT`. There is no added data latency in BUSY.
- Grant latency:
  - A source valid in an IDLE cycle t is granted at edge t+1.
  - Its first beat is presented on `TX_TLP` during cycle t+1.
- Per-packet overhead:
  - The end beat accepted at edge t gives IDLE in cycle t+1.
  - The next TLP's first beat appears in cycle t+2, so there is exactly one bubble cycle per TLP.
- Backpressure: with `TX_TLP_READY` = 0, state and data hold and are not advanced.
- `BUSY` = (state == BUSY), driven from a register.
- Downstream contract: `TX_TLP_VALID` never deasserts without an accept, provided the granted source obeys the same rule.

## Test plan
- **Single source:** source 0 sends a 3-beat TLP with `TX_TLP_READY` = 1.
  - `GRANT` = 3'b001 one cycle after valid.
  - 3 consecutive `TX_TLP_VALID` beats with data matching.
  - IDLE one cycle after the end beat; `BUSY` follows.
- **Round-robin:** all 3 sources hold 1-beat TLPs continuously.
  - Grant order is 0,1,2,0,1,2.
  - Exactly one IDLE cycle between packets.
- **Backpressure:** source 1 sends a 4-beat TLP; `TX_TLP_READY` toggles 1,0,0,1,1,0,1.
  - No beat lost or duplicated.
  - `SRC_TLP_READY[1]` mirrors `TX_TLP_READY`; `SRC_TLP_READY[0]` and `SRC_TLP_READY[2]` stay 0.
  - The grant is not released until the 4th beat is accepted.
- **Framing error:** source 2's first beat has start flag = 0.
  - `FRAME_ERR` = 1 after that accept and stays 1 after the TLP completes.
  - The following TLPs are forwarded normally.
- **Reset mid-packet:** `RST_N` is driven low asynchronously during beat 2 of 5.
  - `TX_TLP_VALID`, `GRANT` and `BUSY` go to 0 without waiting for a clock edge.
  - After release, P = 0: with sources 1 and 0 both valid, source 0 is granted first.
